// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deserializer
// Description : Serial-in, parallel-out word assembler with a single-entry
//               valid/ready output slot and a sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    output logic [WIDTH-1:0]         data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     overrun
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    localparam logic [0:0] c_slot_empty = 1'b0;
    localparam logic [0:0] c_slot_full  = 1'b1;

    logic [WIDTH-1:0]   r_sr;
    logic [WIDTH-1:0]   w_sr_next;
    logic [c_cnt_w-1:0] r_bit_count;
    logic [WIDTH-1:0]   r_data;
    logic [0:0]         r_slot_state;
    logic               r_overrun;
    logic               w_complete;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sr_next = {r_sr[WIDTH-2:0], bit_in};
        end else begin : g_lsb_first
            assign w_sr_next = {bit_in, r_sr[WIDTH-1:1]};
        end
    endgenerate

    assign w_complete = bit_valid && (r_bit_count == c_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr         <= '0;
            r_bit_count  <= '0;
            r_data       <= '0;
            r_slot_state <= c_slot_empty;
            r_overrun    <= 1'b0;
        end else begin
            if (bit_valid) begin
                r_sr        <= w_sr_next;
                r_bit_count <= w_complete ? '0 : r_bit_count + 1'b1;
            end
            // A full slot with ready asserted is consumed and refilled on the same edge.
            if (w_complete) begin
                if (r_slot_state == c_slot_empty || out_ready) begin
                    r_data       <= w_sr_next;
                    r_slot_state <= c_slot_full;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_slot_state == c_slot_full && out_ready) begin
                r_slot_state <= c_slot_empty;
            end
        end
    end

    assign data_out  = r_data;
    assign out_valid = (r_slot_state == c_slot_full);
    assign bit_count = r_bit_count;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_deserializer
// Description : Directed self-checking bench for both bit orderings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic [7:0] m_data, l_data;
    logic       m_valid, l_valid, m_ovr, l_ovr;
    logic [2:0] m_cnt, l_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .data_out(m_data), .out_valid(m_valid), .out_ready(out_ready),
        .bit_count(m_cnt), .overrun(m_ovr)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .data_out(l_data), .out_valid(l_valid), .out_ready(out_ready),
        .bit_count(l_cnt), .overrun(l_ovr)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then sample 1 time unit after the rising edge.
    task automatic tick(input logic r, input logic bv, input logic b, input logic rdy);
        reset     = r;
        bit_valid = bv;
        bit_in    = b;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] aa;
        logic [7:0] v55;
        logic [7:0] v3c;
        aa  = 8'hAA;
        v55 = 8'h55;
        v3c = 8'h3C;

        // Reset values with bit_valid high
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1, 1'b1, 1'b0);
            chk("rst_data", m_data, 8'h00);
            chk("rst_valid", {7'd0, m_valid}, 8'h00);
            chk("rst_cnt", {5'd0, m_cnt}, 8'h00);
            chk("rst_ovr", {7'd0, m_ovr}, 8'h00);
        end

        // MSB-first assembly of 0xAA (LSB instance sees 0x55)
        for (int i = 7; i >= 0; i--) begin
            tick(1'b0, 1'b1, aa[i], 1'b0);
            if (i > 0) chk("msb_cnt", {5'd0, m_cnt}, 8'(8 - i));
        end
        chk("msb_data", m_data, 8'hAA);
        chk("msb_valid", {7'd0, m_valid}, 8'h01);
        chk("msb_cnt_wrap", {5'd0, m_cnt}, 8'h00);
        chk("lsb_nogap_data", l_data, 8'h55);

        // LSB-first with a 3-cycle gap after bit 4
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 7; i >= 4; i--) tick(1'b0, 1'b1, aa[i], 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0);
            chk("gap_cnt", {5'd0, l_cnt}, 8'h04);
        end
        for (int i = 3; i >= 0; i--) tick(1'b0, 1'b1, aa[i], 1'b0);
        chk("lsb_gap_data", l_data, 8'h55);
        chk("lsb_gap_valid", {7'd0, l_valid}, 8'h01);

        // Back-to-back: 0xAA then 0x55, consumer ready on the word-2 completion edge
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) tick(1'b0, 1'b1, aa[i], 1'b0);
        chk("b2b_w1_data", m_data, 8'hAA);
        chk("b2b_w1_valid", {7'd0, m_valid}, 8'h01);
        for (int i = 7; i >= 1; i--) begin
            tick(1'b0, 1'b1, v55[i], 1'b0);
            chk("b2b_mid_valid", {7'd0, m_valid}, 8'h01);
            chk("b2b_mid_data", m_data, 8'hAA);
        end
        tick(1'b0, 1'b1, v55[0], 1'b1);
        chk("b2b_w2_data", m_data, 8'h55);
        chk("b2b_w2_valid", {7'd0, m_valid}, 8'h01);
        chk("b2b_ovr", {7'd0, m_ovr}, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b_drain_valid", {7'd0, m_valid}, 8'h00);
        chk("b2b_drain_data", m_data, 8'h55);

        // Overrun: second word dropped while the slot is full
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) tick(1'b0, 1'b1, aa[i], 1'b0);
        chk("ovr_pre", {7'd0, m_ovr}, 8'h00);
        for (int i = 7; i >= 0; i--) tick(1'b0, 1'b1, v55[i], 1'b0);
        chk("ovr_data_kept", m_data, 8'hAA);
        chk("ovr_set", {7'd0, m_ovr}, 8'h01);
        chk("ovr_valid", {7'd0, m_valid}, 8'h01);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_consume_valid", {7'd0, m_valid}, 8'h00);
        chk("ovr_sticky", {7'd0, m_ovr}, 8'h01);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ovr_cleared", {7'd0, m_ovr}, 8'h00);

        // Reset mid-word, then a clean 0x3C
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk("mid_cnt5", {5'd0, m_cnt}, 8'h05);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        chk("mid_rst_cnt", {5'd0, m_cnt}, 8'h00);
        chk("mid_rst_data", m_data, 8'h00);
        for (int i = 7; i >= 0; i--) tick(1'b0, 1'b1, v3c[i], 1'b0);
        chk("mid_msb_data", m_data, 8'h3C);
        chk("mid_lsb_data", l_data, 8'h3C);
        chk("mid_valid", {7'd0, m_valid}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
